operands_dispatch_arb: RTL and testbench
========================================

// Module: operands_dispatch_arb
// PURPOSE
//  Arbitrates NUM_REQS operand-collector streams (VX_operands_if data_t payloads,
//  flattened) onto one execute-unit dispatch port. Round-robin grant; multi-beat
//  store bundles (is_mstore=1 on every beat except the last) are kept contiguous
//  by locking the grant. A 2-entry output FIFO registers the result, so no
//  combinational path runs from out_ready to any in_ready. Sits between the
//  per-issue-slice operand collectors and the shared dispatch/execute stage.
// PARAMETERS
//  NUM_REQS  4  number of requesting operand streams (>=1)
//  DATA_W    64 width of one packed data_t payload (set from $bits(data_t))
//  MSTORE_B  0  bit index of is_mstore in the payload (LSB of packed data_t)
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  reset      in   1                 synchronous, active-low reset
//  in_valid   in   NUM_REQS          per-requester payload valid
//  in_data    in   NUM_REQS*DATA_W   payloads, requester i at [i*DATA_W +: DATA_W]
//  in_ready   out  NUM_REQS          per-requester accept (one-hot or zero)
//  out_valid  out  1                 dispatch payload valid
//  out_data   out  DATA_W            dispatch payload
//  out_sel    out  max(1,clog2(N))   index of requester that produced out_data
//  out_ready  in   1                 dispatch stage accepts
// BEHAVIOUR
//  Reset (reset==0 at clk edge): FIFO emptied, out_valid=0, rr_ptr=0, lock=0,
//   lock_idx=0; in_ready=0 while reset is low. out_data/out_sel don't-care while
//   out_valid=0. A reset mid-bundle drops the lock and any buffered beats.
//  Arbitration (combinational from registered state + in_valid):
//   - can_acc = (fifo_count < 2), from registered count only.
//   - lock=0: grant first valid requester scanning rr_ptr, rr_ptr+1, ... mod N.
//   - lock=1: grant only lock_idx, only if in_valid[lock_idx]; others get no
//     grant even when valid (bubble is allowed and required).
//   - in_ready = grant & {N{can_acc}}; at most one bit set.
//  Transfer (in_valid[i] & in_ready[i]) updates at clk edge:
//   - payload+i pushed to FIFO; visible at out_valid the next cycle (latency 1).
//   - beat is_mstore=1 -> lock=1, lock_idx=i, rr_ptr unchanged.
//   - beat is_mstore=0 -> lock=0, rr_ptr=(i+1) mod N.
//   - no transfer -> rr_ptr, lock, lock_idx hold.
//  Output FIFO: 2 entries, in order; out_valid = (count!=0); out_data/out_sel
//   from head; pop on out_valid & out_ready. Same-cycle push+pop keeps count.
//   Count never exceeds 2 (push only when count<2). Sustains 1 beat/cycle with
//   out_ready held high; with out_ready low, accepts exactly 2 beats then stalls.
//  Payload passed bit-exact; arbiter never inspects bits other than MSTORE_B.
//  NUM_REQS=1: grant reduces to in_valid[0]&can_acc; out_sel constant 0.
//  in_valid may drop without a transfer; payloads need not be held stable then.
// TESTING
//  1 reset low 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0; first
//    grant after release goes to req0, out_valid rises the following cycle.
//  2 all 4 requesters valid, non-store beats, out_ready=1 -> out_sel sequence
//    0,1,2,3,0,... one beat per cycle, payloads match per source.
//  3 req1 sends 3 beats is_mstore=1,1,0 while req0/req2 valid, req1 gapping one
//    cycle mid-bundle -> out_sel 1,1,1 contiguous, bubble on gap, then grant req2.
//  4 out_ready=0 with req0 valid -> exactly 2 beats accepted, in_ready=0 after;
//    raise out_ready -> same 2 beats in order, then flow resumes.
//  5 reset asserted during a locked bundle (1 beat buffered) -> FIFO empty,
//    lock cleared, next grant follows rr_ptr=0 priority.
//  6 random in_valid/out_ready 10k cycles vs reference model -> no loss, no
//    duplication, per-source order kept, no bundle interleave, 0/1-hot in_ready.

Source files
------------

// File: rtl/operands_dispatch_arb.sv
// rtl/operands_dispatch_arb.sv - round-robin operand stream arbiter with store-bundle lock
// Registered 2-entry output FIFO keeps out_ready off the in_ready path.
module operands_dispatch_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATA_W   = 64,
  parameter int MSTORE_B = 0,
  localparam int SEL_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQS-1:0]        i_in_valid,
  input  logic [NUM_REQS*DATA_W-1:0] i_in_data,
  output logic [NUM_REQS-1:0]        o_in_ready,
  output logic                       o_out_valid,
  output logic [DATA_W-1:0]          o_out_data,
  output logic [SEL_W-1:0]           o_out_sel,
  input  logic                       i_out_ready
);

  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_lock;
  logic [SEL_W-1:0]  r_lock_idx;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [SEL_W-1:0]  r_fifo_sel  [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [NUM_REQS-1:0] w_grant;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [SEL_W-1:0]    w_idx;
  logic                w_found;
  logic                w_can_acc;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_push_mstore;
  logic [SEL_W-1:0]    w_next_ptr;

  assign w_can_acc = (r_count < 2'd2);

  // While locked, only the bundle owner may proceed; a gap from it is a bubble.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_idx       = '0;
    w_found     = 1'b0;
    if (r_lock) begin
      if (i_in_valid[r_lock_idx]) begin
        w_grant[r_lock_idx] = 1'b1;
        w_grant_idx         = r_lock_idx;
      end
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        w_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQS);
        if (!w_found && i_in_valid[w_idx]) begin
          w_found        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_grant_idx    = w_idx;
        end
      end
    end
  end

  assign o_in_ready    = (i_reset && w_can_acc) ? w_grant : '0;
  assign w_push        = |(i_in_valid & o_in_ready);
  assign w_push_data   = i_in_data[w_grant_idx*DATA_W +: DATA_W];
  assign w_push_mstore = w_push_data[MSTORE_B];
  assign w_next_ptr    = (w_grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + SEL_W'(1);

  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_fifo_data[r_rd_ptr];
  assign o_out_sel   = r_fifo_sel[r_rd_ptr];
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_sel[r_wr_ptr]  <= w_grant_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
        if (w_push_mstore) begin
          r_lock     <= 1'b1;
          r_lock_idx <= w_grant_idx;
        end else begin
          r_lock   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_operands_dispatch_arb.sv
// tb/tb_operands_dispatch_arb.sv - self-checking bench for operands_dispatch_arb
module tb_operands_dispatch_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    vld;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  always #5 clk = ~clk;

  operands_dispatch_arb #(.NUM_REQS(N), .DATA_W(DW), .MSTORE_B(0)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_in_valid  (vld),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .i_out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int src, input int seq, input logic ms);
    return {16'hA5C3, 32'(seq), 8'(src), 7'h0, ms};
  endfunction

  typedef struct {
    logic [SW-1:0] sel;
    logic [63:0]   data;
  } beat_t;

  int            s_seq [N];
  int            s_left[N];
  beat_t         q[$];
  int            m_rr;
  bit            m_lock;
  int            m_lock_idx;
  bit            last_ms;
  logic [SW-1:0] last_sel;

  logic [N-1:0]  o_rdy;
  logic          o_vld;
  logic [SW-1:0] o_sel;
  logic [63:0]   o_dat;

  task automatic drive();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = mk(i, s_seq[i], s_left[i] > 1);
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    int           g;
    beat_t        b;
    @(negedge clk);
    o_rdy   = in_ready;
    o_vld   = out_valid;
    o_sel   = out_sel;
    o_dat   = out_data;
    exp_rdy = '0;
    g       = -1;
    if (rst_n && q.size() < 2) begin
      if (m_lock) begin
        if (vld[m_lock_idx]) g = m_lock_idx;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && vld[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("in_ready", o_rdy, exp_rdy);
    check("out_valid", o_vld, q.size() != 0);
    if (q.size() != 0 && o_vld) begin
      check("out_sel", o_sel, q[0].sel);
      check("out_data", o_dat, q[0].data);
    end
    if (!rst_n) begin
      q.delete();
      m_rr = 0; m_lock = 0; m_lock_idx = 0; last_ms = 0;
    end else begin
      if (q.size() != 0 && out_ready) begin
        if (last_ms) check("bundle_contig", o_sel, last_sel);
        last_ms  = o_dat[0];
        last_sel = o_sel;
        void'(q.pop_front());
      end
      if (g >= 0) begin
        b.sel  = SW'(g);
        b.data = in_data[g*DW +: DW];
        q.push_back(b);
        if (b.data[0]) begin
          m_lock = 1; m_lock_idx = g;
        end else begin
          m_lock = 0; m_rr = (g + 1) % N;
        end
        s_seq[g]++;
        if (s_left[g] > 0) s_left[g]--;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  logic [3:0] t3_v[6] = '{4'h7, 4'h7, 4'h5, 4'h7, 4'h7, 4'h7};
  logic [3:0] t3_r[6] = '{4'h1, 4'h2, 4'h0, 4'h2, 4'h2, 4'h4};
  logic [3:0] t4_r[4] = '{4'h1, 4'h1, 4'h0, 4'h0};
  int base;

  initial begin
    for (int i = 0; i < N; i++) begin s_seq[i] = 0; s_left[i] = 0; end
    m_rr = 0; m_lock = 0; m_lock_idx = 0; last_ms = 0; last_sel = '0;
    rst_n = 1'b0; vld = 4'hF; out_ready = 1'b1;
    drive();

    repeat (3) begin
      step();
      check("rst_rdy", o_rdy, 0);
      check("rst_vld", o_vld, 0);
    end

    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_rdy", o_rdy, 64'd1 << (k % 4));
      if (k > 0) begin
        check("rr_vld", o_vld, 1);
        check("rr_sel", o_sel, (k - 1) % 4);
      end
    end

    s_left[1] = 3;
    for (int k = 0; k < 6; k++) begin
      vld = t3_v[k];
      drive();
      step();
      check("bundle_rdy", o_rdy, t3_r[k]);
    end
    vld = '0; drive();
    repeat (2) step();

    out_ready = 1'b0; vld = 4'h1; base = s_seq[0];
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_rdy", o_rdy, t4_r[k]);
    end
    check("stall_vld", o_vld, 1);
    check("stall_sel", o_sel, 0);
    out_ready = 1'b1;
    step();
    check("resume_rdy0", o_rdy, 0);
    check("resume_d0", o_dat, mk(0, base, 1'b0));
    step();
    check("resume_rdy1", o_rdy, 1);
    check("resume_d1", o_dat, mk(0, base + 1, 1'b0));
    vld = '0; drive();
    repeat (2) step();

    out_ready = 1'b0; s_left[2] = 3; vld = 4'b1100;
    drive();
    step();
    check("lock_rdy", o_rdy, 4'b0100);
    rst_n = 1'b0; vld = 4'b1001; s_left[2] = 0;
    drive();
    step();
    check("midrst_rdy", o_rdy, 0);
    check("midrst_vld", o_vld, 1);
    rst_n = 1'b1;
    step();
    check("postrst_vld", o_vld, 0);
    check("postrst_rdy", o_rdy, 4'b0001);
    out_ready = 1'b1; vld = '0; drive();
    repeat (2) step();

    repeat (10000) begin
      vld       = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (s_left[i] == 0 && $urandom_range(0, 7) == 0) s_left[i] = $urandom_range(2, 4);
      drive();
      step();
    end

    vld = '0; out_ready = 1'b1; drive();
    repeat (4) step();
    check("drain_empty", q.size(), 0);
    check("drain_vld", o_vld, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
